// File: rtl/misc_result_accum.sv
// rtl/misc_result_accum.sv - windowed accumulator for the Misc XOUT1/XOUT2 result streams
//
// Purpose: accepts XOUT1/XOUT2 samples on a valid/ready handshake, sums each stream over a
// window of WINDOW samples and presents the per-window sums on a registered valid/ready
// output. A sticky overflow flag records any carry out of ACC_W bits.
//
// Optional feature: define MISC_RESULT_ACC_MINMAX_EN to add MAX1/MIN1 outputs holding the
// largest/smallest XOUT1 sample of each window.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   in_valid_i   sample present on xout1_i/xout2_i
//   in_ready_o   sample accepted this cycle when in_valid_i is also high
//   xout1_i      sample stream 1 (NX bits, unsigned)
//   xout2_i      sample stream 2 (NX bits, unsigned)
//   out_valid_o  sum1_o/sum2_o hold a completed window
//   out_ready_i  consumer takes the window result
//   sum1_o       window sum of stream 1, modulo 2**ACC_W
//   sum2_o       window sum of stream 2, modulo 2**ACC_W
//   ovf_o        sticky carry-out flag, cleared only by reset
//   max1_o       (MISC_RESULT_ACC_MINMAX_EN) largest stream-1 sample of the window
//   min1_o       (MISC_RESULT_ACC_MINMAX_EN) smallest stream-1 sample of the window
module misc_result_accum #(
    parameter int NX     = 8,
    parameter int WINDOW = 4,
    parameter int ACC_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [NX-1:0]    xout1_i,
    input  logic [NX-1:0]    xout2_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [ACC_W-1:0] sum1_o,
    output logic [ACC_W-1:0] sum2_o,
`ifdef MISC_RESULT_ACC_MINMAX_EN
    output logic [NX-1:0]    max1_o,
    output logic [NX-1:0]    min1_o,
`endif
    output logic             ovf_o
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WINDOW - 1);
    localparam int PAD = ACC_W + 1 - NX;

    typedef enum logic {
        S_ACCUM = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t            state_q;
    logic [ACC_W-1:0]  acc1_q;
    logic [ACC_W-1:0]  acc2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid_q;
    logic [ACC_W-1:0]  sum1_q;
    logic [ACC_W-1:0]  sum2_q;
    logic              ovf_q;

    logic              accept;
    logic              last;
    logic [ACC_W:0]    add1_d;
    logic [ACC_W:0]    add2_d;

    // In HOLD the input is ready only when the result is drained in the same cycle,
    // so the next window can start without a bubble.
    assign in_ready_o = (state_q == S_ACCUM) || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign last       = (cnt_q == CNT_LAST);

    // One extra bit captures the carry that feeds the sticky overflow flag.
    assign add1_d = {1'b0, acc1_q} + {{PAD{1'b0}}, xout1_i};
    assign add2_d = {1'b0, acc2_q} + {{PAD{1'b0}}, xout2_i};

`ifdef MISC_RESULT_ACC_MINMAX_EN
    logic [NX-1:0] trk_max_q;
    logic [NX-1:0] trk_min_q;
    logic [NX-1:0] max1_q;
    logic [NX-1:0] min1_q;
    logic [NX-1:0] run_max_d;
    logic [NX-1:0] run_min_d;

    // cnt_q is zero for the first sample of every window, which seeds both trackers.
    assign run_max_d = (cnt_q == '0) ? xout1_i : ((xout1_i > trk_max_q) ? xout1_i : trk_max_q);
    assign run_min_d = (cnt_q == '0) ? xout1_i : ((xout1_i < trk_min_q) ? xout1_i : trk_min_q);
    assign max1_o    = max1_q;
    assign min1_o    = min1_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_ACCUM;
            acc1_q      <= '0;
            acc2_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            sum1_q      <= '0;
            sum2_q      <= '0;
            ovf_q       <= 1'b0;
`ifdef MISC_RESULT_ACC_MINMAX_EN
            trk_max_q   <= '0;
            trk_min_q   <= '0;
            max1_q      <= '0;
            min1_q      <= '0;
`endif
        end else begin
            case (state_q)
                S_ACCUM: begin
                    if (accept) begin
                        ovf_q <= ovf_q | add1_d[ACC_W] | add2_d[ACC_W];
                        if (last) begin
                            sum1_q      <= add1_d[ACC_W-1:0];
                            sum2_q      <= add2_d[ACC_W-1:0];
                            acc1_q      <= '0;
                            acc2_q      <= '0;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b1;
                            state_q     <= S_HOLD;
`ifdef MISC_RESULT_ACC_MINMAX_EN
                            max1_q      <= run_max_d;
                            min1_q      <= run_min_d;
`endif
                        end else begin
                            acc1_q <= add1_d[ACC_W-1:0];
                            acc2_q <= add2_d[ACC_W-1:0];
                            cnt_q  <= cnt_q + CNT_W'(1);
`ifdef MISC_RESULT_ACC_MINMAX_EN
                            trk_max_q <= run_max_d;
                            trk_min_q <= run_min_d;
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (out_ready_i) begin
                        state_q     <= S_ACCUM;
                        out_valid_q <= 1'b0;
                        // acc/cnt were cleared on entry to HOLD, so the adders yield the
                        // bare sample and this accept becomes sample 1 of the next window.
                        if (accept) begin
                            acc1_q <= add1_d[ACC_W-1:0];
                            acc2_q <= add2_d[ACC_W-1:0];
                            cnt_q  <= CNT_W'(1);
`ifdef MISC_RESULT_ACC_MINMAX_EN
                            trk_max_q <= run_max_d;
                            trk_min_q <= run_min_d;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= S_ACCUM;
                end
            endcase
        end
    end

    assign out_valid_o = out_valid_q;
    assign sum1_o      = sum1_q;
    assign sum2_o      = sum2_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_misc_result_accum.sv
// tb/tb_misc_result_accum.sv - self-checking bench for misc_result_accum (ACC_W=16 and ACC_W=8)
module tb_misc_result_accum;

    localparam int WINDOW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  x1 = '0;
    logic [7:0]  x2 = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, in_ready8;
    logic        out_valid, out_valid8;
    logic [15:0] sum1, sum2;
    logic [7:0]  sum1_8, sum2_8;
    logic        ovf, ovf8;
`ifdef MISC_RESULT_ACC_MINMAX_EN
    logic [7:0]  max1, min1, max1_8, min1_8;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    typedef struct {
        int s1; int s2; int o;
        int s1b; int s2b; int ob;
        int mx; int mn;
    } exp_t;
    exp_t sb[$];

    // reference model state
    bit m_hold;
    int m_cnt, m_a1, m_a2, m_b1, m_b2, m_mx, m_mn;
    bit m_ovf, m_ovf8;

    always #5 clk = ~clk;

    misc_result_accum #(.NX(8), .WINDOW(WINDOW), .ACC_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .xout1_i(x1), .xout2_i(x2), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sum1_o(sum1), .sum2_o(sum2),
`ifdef MISC_RESULT_ACC_MINMAX_EN
        .max1_o(max1), .min1_o(min1),
`endif
        .ovf_o(ovf)
    );

    misc_result_accum #(.NX(8), .WINDOW(WINDOW), .ACC_W(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready8),
        .xout1_i(x1), .xout2_i(x2), .out_valid_o(out_valid8), .out_ready_i(out_ready),
        .sum1_o(sum1_8), .sum2_o(sum2_8),
`ifdef MISC_RESULT_ACC_MINMAX_EN
        .max1_o(max1_8), .min1_o(min1_8),
`endif
        .ovf_o(ovf8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_hold = 0; m_cnt = 0;
        m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0;
        m_mx = 0; m_mn = 0;
        m_ovf = 0; m_ovf8 = 0;
        sb.delete();
    endtask

    // Runs at the falling edge: checks handshake/outputs, then advances the model
    // by what the coming rising edge will do.
    task automatic monitor();
        logic exp_rdy;
        exp_t e;
        exp_rdy = !m_hold || out_ready;
        chk("in_ready", in_ready, exp_rdy);
        chk("in_ready8", in_ready8, exp_rdy);
        chk("out_valid", out_valid, m_hold);
        chk("out_valid8", out_valid8, m_hold);
        if (m_hold) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb[0];
                chk("sum1", sum1, e.s1);
                chk("sum2", sum2, e.s2);
                chk("ovf", ovf, e.o);
                chk("sum1_8", sum1_8, e.s1b);
                chk("sum2_8", sum2_8, e.s2b);
                chk("ovf8", ovf8, e.ob);
`ifdef MISC_RESULT_ACC_MINMAX_EN
                chk("max1", max1, e.mx);
                chk("min1", min1, e.mn);
                chk("max1_8", max1_8, e.mx);
                chk("min1_8", min1_8, e.mn);
`endif
                if (out_ready) void'(sb.pop_front());
            end
            if (out_ready) m_hold = 0;
        end
        if (in_valid && exp_rdy) begin
            if (m_cnt == 0) begin m_mx = x1; m_mn = x1; end
            else begin
                if (x1 > m_mx) m_mx = x1;
                if (x1 < m_mn) m_mn = x1;
            end
            m_a1 += x1; m_a2 += x2;
            if (m_a1 > 65535 || m_a2 > 65535) m_ovf = 1;
            m_a1 &= 65535; m_a2 &= 65535;
            m_b1 += x1; m_b2 += x2;
            if (m_b1 > 255 || m_b2 > 255) m_ovf8 = 1;
            m_b1 &= 255; m_b2 &= 255;
            m_cnt++;
            if (m_cnt == WINDOW) begin
                e.s1 = m_a1; e.s2 = m_a2; e.o = m_ovf;
                e.s1b = m_b1; e.s2b = m_b2; e.ob = m_ovf8;
                e.mx = m_mx; e.mn = m_mn;
                sb.push_back(e);
                m_hold = 1;
                m_cnt = 0; m_a1 = 0; m_a2 = 0; m_b1 = 0; m_b2 = 0;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
        in_valid = v;
        x1 = v ? a : 8'hxx;
        x2 = v ? b : 8'hxx;
        out_ready = r;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic v);
        rst = 1'b1;
        in_valid = v; x1 = 8'd10; x2 = 8'd10; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum1", sum1, 0);
        chk("rst_sum2", sum2, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out_valid8", out_valid8, 0);
        chk("rst_sum1_8", sum1_8, 0);
        chk("rst_ovf8", ovf8, 0);
`ifdef MISC_RESULT_ACC_MINMAX_EN
        chk("rst_max1", max1, 0);
        chk("rst_min1", min1, 0);
`endif
        rst = 1'b0;
        model_clear();
    endtask

    initial begin
        model_clear();
        @(posedge clk);
        #1;
        do_reset(1'b0);
        chk("rst_in_ready", in_ready, 1);

        // 1: back-to-back window, drained immediately
        step(1, 1, 2, 1); step(1, 3, 4, 1); step(1, 5, 6, 1); step(1, 7, 8, 1);
        chk("t1_valid", out_valid, 1);
        chk("t1_sum1", sum1, 16);
        chk("t1_sum2", sum2, 20);
        chk("t1_ovf", ovf, 0);
        step(0, 0, 0, 1);
        chk("t1_drop", out_valid, 0);

        // 2: back-pressure holds the result and stalls input
        step(1, 1, 2, 0); step(1, 3, 4, 0); step(1, 5, 6, 0); step(1, 7, 8, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 99, 99, 0);
            chk("t2_valid", out_valid, 1);
            chk("t2_sum1", sum1, 16);
            chk("t2_sum2", sum2, 20);
            chk("t2_in_ready", in_ready, 0);
        end

        // 3: drain overlaps first sample of next window
        step(1, 9, 1, 1); step(1, 1, 1, 1); step(1, 1, 1, 1); step(1, 1, 1, 1);
        chk("t3_valid", out_valid, 1);
        chk("t3_sum1", sum1, 12);
        chk("t3_sum2", sum2, 4);
        step(0, 0, 0, 1);

        // 4: wrap-around and sticky overflow on the 8-bit instance
        for (int i = 0; i < 4; i++) step(1, 255, 0, 1);
        chk("t4_sum1_8", sum1_8, 252);
        chk("t4_ovf8", ovf8, 1);
        chk("t4_sum1_16", sum1, 1020);
        chk("t4_ovf16", ovf, 0);
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
        chk("t4_ovf8_sticky", ovf8, 1);
        chk("t4_sum1_8_clean", sum1_8, 4);
        step(0, 0, 0, 1);

        // 5: reset drops a partial window
        step(1, 10, 10, 1); step(1, 10, 10, 1);
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1);
        chk("t5_sum1", sum1, 4);
        chk("t5_sum2", sum2, 4);
        chk("t5_ovf8", ovf8, 0);
        step(0, 0, 0, 1);

        // 6: min/max tracking (sum checked in every build)
        step(1, 7, 0, 1); step(1, 200, 0, 1); step(1, 3, 0, 1); step(1, 50, 0, 1);
        chk("t6_valid", out_valid, 1);
        chk("t6_sum1", sum1, 260);
`ifdef MISC_RESULT_ACC_MINMAX_EN
        chk("t6_max1", max1, 200);
        chk("t6_min1", min1, 3);
`endif
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
